fetch_prefetch: RTL

Parametrised next-generation instruction fetch stage with a prefetch queue between the PC/instruction-memory side and the IF/ID pipeline register.
- Decouples memory fetch from decode stalls.
- Handles redirects with queue flush and in-flight squash.
- Sits between the instruction RAM (synchronous, 1-cycle read) and decode/issue/execute.

---
 rtl/fetch_pkg.sv | 27 ++
 rtl/fetch_queue.sv | 73 +++++++
 rtl/fetch_prefetch.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage with prefetch queue.
//   - PC source select encodings driven by decode on id_if_selpctype
//   - NOP_INSTR: the all-zero bubble presented to decode
//   - Default reset and trap vectors
//   - fq_entry_t: one prefetch queue entry {instruction word, its PC+4}
package fetch_pkg;

  // Width of the datapath the queue entry type is built for.
  localparam int FQ_XLEN = 32;

  typedef enum logic [1:0] {
    PCSEL_IMD   = 2'b00,  // PC-relative branch target
    PCSEL_REGA  = 2'b01,  // register-indirect target
    PCSEL_INDEX = 2'b10,  // absolute jump target
    PCSEL_TRAP  = 2'b11   // fixed trap vector
  } pcsel_e;

  localparam logic [FQ_XLEN-1:0] NOP_INSTR        = '0;
  localparam logic [FQ_XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [FQ_XLEN-1:0] DEFAULT_TRAP_PC  = 32'h0000_0040;

  typedef struct packed {
    logic [FQ_XLEN-1:0] instr;
    logic [FQ_XLEN-1:0] nextpc;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO holding prefetched instructions between the instruction
// RAM and the IF/ID register.
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-low reset
//   push, push_data   write one entry (accepted when not full, or full and
//                     popping in the same cycle)
//   pop, pop_data     head entry (combinational) and its removal strobe
//   flush             empty the queue; wins over a same-cycle push
//   count             occupancy, 0..DEPTH
//   full, empty       occupancy flags
module fetch_queue #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           pop_data,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign pop_ok   = pop & ~empty;
  // A push into a full queue is only safe when the head leaves this cycle.
  assign push_ok  = push & (~full | pop_ok);
  // Head is read straight from storage, so an entry pushed into an empty
  // queue becomes visible one cycle later (no bypass).
  assign pop_data = mem[rd_ptr];

  // NOTE: storage carries no reset; the pointers and count alone define
  // which entries are meaningful, and leaving the array unreset keeps it a
  // plain RAM.
  always_ff @(posedge clock) begin
    if (push_ok && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap naturally.
      wr_ptr <= wr_ptr + AW'(push_ok);
      rd_ptr <= rd_ptr + AW'(pop_ok);
      count  <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/fetch_prefetch.sv
// Instruction fetch stage with a prefetch queue. The PC side issues reads to
// a synchronous 1-cycle instruction RAM whenever the queue has room; returned
// words are queued with their PC+4 and handed to the IF/ID register as decode
// consumes them. Redirects flush the queue and squash any in-flight read.
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-low reset
//   iss_stall               hold IF/ID outputs
//   ex_if_stall             inject a bubble into IF/ID, hold the queue head
//   id_if_selpcsource       take a redirect
//   id_if_selpctype         redirect source (see pcsel_e)
//   id_if_rega/pcimd2ext/pcindex  candidate redirect targets
//   imem_addr, imem_rd      RAM word address and read strobe
//   imem_data               RAM data, valid the cycle after imem_rd
//   if_id_instruc/nextpc/valid    IF/ID register
//   fq_count                prefetch queue occupancy
module fetch_prefetch
  import fetch_pkg::*;
#(
  parameter int             XLEN     = FQ_XLEN,
  parameter int             IMEM_AW  = 7,
  parameter int             FQ_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [XLEN-1:0] TRAP_PC  = DEFAULT_TRAP_PC
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      iss_stall,
  input  logic                      ex_if_stall,
  input  logic                      id_if_selpcsource,
  input  logic [1:0]                id_if_selpctype,
  input  logic [XLEN-1:0]           id_if_rega,
  input  logic [XLEN-1:0]           id_if_pcimd2ext,
  input  logic [XLEN-1:0]           id_if_pcindex,
  output logic [IMEM_AW-1:0]        imem_addr,
  output logic                      imem_rd,
  input  logic [XLEN-1:0]           imem_data,
  output logic [XLEN-1:0]           if_id_instruc,
  output logic [XLEN-1:0]           if_id_nextpc,
  output logic                      if_id_valid,
  output logic [$clog2(FQ_DEPTH):0] fq_count
);

  localparam int CW = $clog2(FQ_DEPTH) + 1;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_req;
  logic            inflight;
  logic [XLEN-1:0] target;
  logic            redirect_take;
  logic            pop;
  logic            push;
  logic            fq_full;
  logic            fq_empty;
  logic [CW:0]     occupancy;
  fq_entry_t       push_entry;
  fq_entry_t       head;

  // NOTE: every signal assigned in always_comb gets a value on every path;
  // the explicit default keeps this purely combinational (no latch).
  always_comb begin
    target = 'x;  // unknown select propagates as unknown PC
    case (id_if_selpctype)
      PCSEL_IMD:   target = id_if_pcimd2ext;
      PCSEL_REGA:  target = id_if_rega;
      PCSEL_INDEX: target = id_if_pcindex;
      PCSEL_TRAP:  target = TRAP_PC;
      default:     target = 'x;
    endcase
  end

  // Either stall masks the redirect; decode re-presents it afterwards.
  assign redirect_take = id_if_selpcsource & ~ex_if_stall & ~iss_stall;
  assign pop           = ~ex_if_stall & ~iss_stall & ~id_if_selpcsource & ~fq_empty;

  // Entries after this edge = queued + returning response - departing head.
  // A new read is only issued if its response is guaranteed a slot.
  assign occupancy = {1'b0, fq_count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
  assign imem_rd   = reset & ~redirect_take & (occupancy < (CW + 1)'(FQ_DEPTH));
  assign imem_addr = pc[IMEM_AW+1:2];

  // The returning word of a read issued last cycle. On a redirect the queue
  // flush overrides this push, which is what squashes the in-flight word.
  assign push              = inflight & (~fq_full | pop);
  assign push_entry.instr  = imem_data;
  assign push_entry.nextpc = pc_req + XLEN'(4);

  fetch_queue #(
    .W     ($bits(fq_entry_t)),
    .DEPTH (FQ_DEPTH)
  ) u_queue (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head),
    .flush     (redirect_take),
    .count     (fq_count),
    .full      (fq_full),
    .empty     (fq_empty)
  );

  // PC and in-flight tracking. No read is issued in a redirect cycle, so
  // inflight clears and the first target read goes out the following cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc       <= RESET_PC;
      pc_req   <= RESET_PC;
      inflight <= 1'b0;
    end else begin
      inflight <= imem_rd;
      if (imem_rd) begin
        pc_req <= pc;
      end
      if (redirect_take) begin
        pc <= target;
      end else if (imem_rd) begin
        pc <= pc + XLEN'(4);
      end
    end
  end

  // IF/ID register, priority ex_if_stall > iss_stall > redirect > normal.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      if_id_instruc <= NOP_INSTR;
      if_id_nextpc  <= RESET_PC;
      if_id_valid   <= 1'b0;
    end else if (ex_if_stall) begin
      if_id_instruc <= NOP_INSTR;
      if_id_nextpc  <= pc;
      if_id_valid   <= 1'b0;
    end else if (iss_stall) begin
      if_id_instruc <= if_id_instruc;
      if_id_nextpc  <= if_id_nextpc;
      if_id_valid   <= if_id_valid;
    end else if (id_if_selpcsource) begin
      if_id_instruc <= NOP_INSTR;
      if_id_nextpc  <= target;
      if_id_valid   <= 1'b0;
    end else if (!fq_empty) begin
      if_id_instruc <= head.instr;
      if_id_nextpc  <= head.nextpc;
      if_id_valid   <= 1'b1;
    end else begin
      // Queue dry: bubble, keep the last nextpc.
      if_id_instruc <= NOP_INSTR;
      if_id_valid   <= 1'b0;
    end
  end

endmodule
